// File: rtl/matmul_acc_pkg.sv
// Shared widths and FSM encoding for the matmul dot-product accumulator.
package matmul_acc_pkg;
  localparam int PROD_W_DEF = 87;
  localparam int ACC_W_DEF  = 104;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;
endpackage

// File: rtl/matmul_product_accumulator.sv
// Sums k_len unsigned products from the multiplier stage into one saturating
// dot-product result, presented on a valid/ready output port.
module matmul_product_accumulator
  import matmul_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  k_len,
  output logic              busy,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              sum_ovf
);

  // Returns {ovf, acc}: a carry out of the top bit, or an earlier overflow,
  // pins the accumulator at all-ones for the remainder of the group.
  function automatic logic [ACC_W:0] acc_sat(input logic [ACC_W-1:0]  acc,
                                             input logic               ovf,
                                             input logic [PROD_W-1:0]  prod);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    if (ovf || s[ACC_W]) begin
      acc_sat = {1'b1, {ACC_W{1'b1}}};
    end else begin
      acc_sat = s;
    end
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   k_lat;
  logic [CNT_W-1:0]   cnt_p0;
  logic [ACC_W-1:0]   acc_p0;
  logic               ovf_p0;
  logic [ACC_W-1:0]   sum_p1;
  logic               ovf_p1;
  logic [ACC_W:0]     acc_nxt;
  logic               hs;
  logic               last;
  logic               accept;

  assign acc_nxt = acc_sat(acc_p0, ovf_p0, prod_data);
  assign hs      = prod_valid & prod_ready;
  assign last    = hs && ((cnt_p0 + CNT_W'(1)) == k_lat);
  assign accept  = (state_q == IDLE) && start;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (k_len == '0) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (last) begin
          state_d = OUT;
        end
      end
      OUT: begin
        sum_valid = 1'b1;
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage p0: running accumulation; stage p1: completed sum held for output.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      k_lat  <= '0;
      cnt_p0 <= '0;
      acc_p0 <= '0;
      ovf_p0 <= 1'b0;
      sum_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (accept) begin
      k_lat  <= k_len;
      cnt_p0 <= '0;
      acc_p0 <= '0;
      ovf_p0 <= 1'b0;
      if (k_len == '0) begin
        sum_p1 <= '0;
        ovf_p1 <= 1'b0;
      end
    end else if (hs) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
      acc_p0 <= acc_nxt[ACC_W-1:0];
      ovf_p0 <= acc_nxt[ACC_W];
      if (last) begin
        sum_p1 <= acc_nxt[ACC_W-1:0];
        ovf_p1 <= acc_nxt[ACC_W];
      end
    end
  end

  assign sum_data = sum_p1;
  assign sum_ovf  = ovf_p1;

endmodule

// File: tb/tb_matmul_product_accumulator.sv
// Scenario bench for matmul_product_accumulator with a narrow accumulator so
// saturation is reachable; expected sums come from plain wide-integer totals.
module tb_matmul_product_accumulator;
  localparam int PROD_W = 87;
  localparam int ACC_W  = 88;
  localparam int CNT_W  = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              start;
  logic [CNT_W-1:0]  k_len;
  logic              busy;
  logic [PROD_W-1:0] prod_data;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  sum_data;
  logic              sum_valid;
  logic              sum_ready;
  logic              sum_ovf;

  matmul_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .k_len(k_len), .busy(busy),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .sum_data(sum_data), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_ovf(sum_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;
  int ready_cnt = 0;
  int sum_hs_cnt = 0;

  always @(posedge ap_clk) begin
    if (prod_ready) ready_cnt++;
    if (sum_valid && sum_ready) sum_hs_cnt++;
  end

  logic [PROD_W-1:0] prod_vals [0:15];
  logic [ACC_W-1:0]  got_sum;
  logic              got_ovf;
  bit                lat_ok, ready_ok, stable_ok, idle_ok;
  int                period;

  function automatic logic [PROD_W-1:0] rand_prod();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PROD_W-1:0];
  endfunction

  // Expected {ovf, sum}: products are non-negative, so the group overflows
  // exactly when the true total exceeds the accumulator range.
  function automatic logic [ACC_W:0] ref_sum(input int k);
    logic [127:0] t;
    logic [127:0] mx;
    t  = '0;
    mx = (128'(1) << ACC_W) - 128'(1);
    for (int i = 0; i < k; i++) t += 128'(prod_vals[i]);
    if (t > mx) return {1'b1, {ACC_W{1'b1}}};
    return {1'b0, t[ACC_W-1:0]};
  endfunction

  // Runs one group starting at a falling edge; records observations only.
  task automatic drive_group(input int k, input int gap_mode, input int stall, input bit hold);
    int idx;
    int guard;
    bit v;
    bit phase;
    lat_ok = 1; ready_ok = 1; stable_ok = 1; idle_ok = 1; period = 0;
    start = 1'b1;
    k_len = CNT_W'(k);
    @(negedge ap_clk); period++;
    start = hold;
    idx = 0; guard = 0; phase = 1'b1;
    while (idx < k && guard < 200) begin
      if (!prod_ready || sum_valid) ready_ok = 0;
      case (gap_mode)
        0: v = 1'b1;
        1: begin v = phase; phase = ~phase; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      prod_valid = v;
      prod_data  = v ? prod_vals[idx] : rand_prod();
      @(negedge ap_clk); period++; guard++;
      if (v) idx++;
    end
    prod_valid = 1'b0;
    if (guard >= 200) lat_ok = 0;
    if (!sum_valid) lat_ok = 0;
    got_sum = sum_data;
    got_ovf = sum_ovf;
    for (int s = 0; s < stall; s++) begin
      sum_ready = 1'b0;
      @(negedge ap_clk); period++;
      if (!sum_valid || sum_data !== got_sum || sum_ovf !== got_ovf) stable_ok = 0;
    end
    sum_ready = 1'b1;
    @(negedge ap_clk); period++;
    sum_ready = 1'b0;
    if (busy || sum_valid) idle_ok = 0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; start = 1'b0; k_len = '0; prod_data = '0; prod_valid = 1'b0; sum_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    n_vec++; if ({busy, prod_ready, sum_valid, sum_ovf} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0000", {busy, prod_ready, sum_valid, sum_ovf}); end
    n_vec++; if (sum_data !== '0) begin
      n_err++; $display("FAIL reset_sum got %0h want 0", sum_data); end
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) prod_vals[i] = PROD_W'(i + 1);
    drive_group(4, 0, 0, 1'b0);
    n_vec++; if (got_sum !== ACC_W'(10)) begin n_err++; $display("FAIL basic_sum got %0d want 10", got_sum); end
    n_vec++; if (got_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", got_ovf); end
    n_vec++; if (!lat_ok) begin n_err++; $display("FAIL basic_latency sum_valid got 0 want 1 after 4th product"); end
    n_vec++; if (!ready_ok) begin n_err++; $display("FAIL basic_ready prod_ready got 0 want 1 in ACCUM"); end
    n_vec++; if (period !== 6) begin n_err++; $display("FAIL basic_period got %0d want 6", period); end
    n_vec++; if (!idle_ok) begin n_err++; $display("FAIL basic_idle busy got 1 want 0 after output"); end
  endtask

  task automatic test_zero_len();
    int r0;
    r0 = ready_cnt;
    drive_group(0, 0, 0, 1'b0);
    n_vec++; if (!lat_ok) begin n_err++; $display("FAIL zero_latency sum_valid got 0 want 1"); end
    n_vec++; if (got_sum !== '0 || got_ovf !== 1'b0) begin
      n_err++; $display("FAIL zero_sum got %0d/%b want 0/0", got_sum, got_ovf); end
    n_vec++; if (ready_cnt !== r0) begin
      n_err++; $display("FAIL zero_ready prod_ready cycles got %0d want 0", ready_cnt - r0); end
  endtask

  task automatic test_gaps();
    prod_vals[0] = 5; prod_vals[1] = 7; prod_vals[2] = 9;
    drive_group(3, 1, 5, 1'b0);
    n_vec++; if (got_sum !== ACC_W'(21)) begin n_err++; $display("FAIL gaps_sum got %0d want 21", got_sum); end
    n_vec++; if (!stable_ok) begin n_err++; $display("FAIL gaps_hold sum not stable got changed want %0d", got_sum); end
    n_vec++; if (!idle_ok) begin n_err++; $display("FAIL gaps_idle busy got 1 want 0"); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) prod_vals[i] = {PROD_W{1'b1}};
    drive_group(3, 0, 1, 1'b0);
    n_vec++; if (got_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", got_ovf); end
    n_vec++; if (got_sum !== {ACC_W{1'b1}}) begin n_err++; $display("FAIL ovf_sat got %0h want all-ones", got_sum); end
    n_vec++; if (!stable_ok) begin n_err++; $display("FAIL ovf_hold sum not stable got changed want held"); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; k_len = CNT_W'(5);
    @(negedge ap_clk);
    start = 1'b0; prod_valid = 1'b1; prod_data = 100;
    @(negedge ap_clk);
    prod_data = 200;
    @(negedge ap_clk);
    prod_valid = 1'b0;
    #1 ap_rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, prod_ready, sum_valid, sum_ovf} !== 4'b0 || sum_data !== '0) begin
      n_err++; $display("FAIL midreset_outputs got %b/%0d want 0000/0", {busy, prod_ready, sum_valid, sum_ovf}, sum_data); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    prod_vals[0] = 9;
    drive_group(1, 0, 0, 1'b0);
    n_vec++; if (got_sum !== ACC_W'(9) || got_ovf !== 1'b0) begin
      n_err++; $display("FAIL midreset_sum got %0d/%b want 9/0", got_sum, got_ovf); end
    n_vec++; if (!lat_ok || !ready_ok || period !== 3) begin
      n_err++; $display("FAIL midreset_timing got period %0d want 3", period); end
  endtask

  task automatic test_start_held();
    int h0;
    h0 = sum_hs_cnt;
    for (int i = 0; i < 3; i++) prod_vals[i] = PROD_W'(1000 * (i + 1));
    drive_group(3, 0, 2, 1'b1);
    @(negedge ap_clk);
    n_vec++; if (got_sum !== ACC_W'(6000)) begin n_err++; $display("FAIL held_sum got %0d want 6000", got_sum); end
    n_vec++; if (!idle_ok || busy !== 1'b0) begin n_err++; $display("FAIL held_restart busy got 1 want 0"); end
    n_vec++; if (sum_hs_cnt - h0 !== 1) begin
      n_err++; $display("FAIL held_count sums got %0d want 1", sum_hs_cnt - h0); end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W:0] exp;
    int k;
    int gm;
    int st;
    for (int g = 0; g < 20; g++) begin
      k  = $urandom_range(1, 8);
      gm = (g % 3 == 0) ? 0 : 2;
      st = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        case ($urandom_range(0, 3))
          0: prod_vals[i] = {PROD_W{1'b1}};
          1: prod_vals[i] = rand_prod();
          default: prod_vals[i] = PROD_W'($urandom_range(0, 100000));
        endcase
      end
      exp = ref_sum(k);
      drive_group(k, gm, st, 1'b0);
      n_vec++; if ({got_ovf, got_sum} !== exp) begin
        n_err++; $display("FAIL rand_sum g%0d got %b/%0h want %b/%0h", g, got_ovf, got_sum, exp[ACC_W], exp[ACC_W-1:0]); end
      n_vec++; if (!lat_ok || !ready_ok || !stable_ok || !idle_ok) begin
        n_err++; $display("FAIL rand_protocol g%0d got flags %b%b%b%b want 1111", g, lat_ok, ready_ok, stable_ok, idle_ok); end
      if (gm == 0) begin
        n_vec++; if (period !== k + 2 + st) begin
          n_err++; $display("FAIL rand_period g%0d got %0d want %0d", g, period, k + 2 + st); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_overflow();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
